// File: rtl/controller_responder.sv
// Serial game-controller responder: latches button state on a poll pulse and
// shifts it out bit-by-bit (active-low) on each sample strobe from the reader.
module controller_responder #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 2000
) (
  input  logic             SYSCLK,
  input  logic             NSYSRESET,
  input  logic             poll,
  input  logic             sample,
  input  logic [WIDTH-1:0] buttons,
  output logic             data,
  output logic             busy,
  output logic             frame_done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_e;

  state_e             state_q, state_d;
  logic [1:0]         poll_sync_q;
  logic [2:0]         sample_sync_q;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               data_q, data_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;

  logic poll_lvl;
  logic sample_rise;

  assign poll_lvl    = poll_sync_q[1];
  // The third sample flop only exists to remember the previous synchronized level.
  assign sample_rise = sample_sync_q[1] & ~sample_sync_q[2];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state_q       <= IDLE;
      poll_sync_q   <= '0;
      sample_sync_q <= '0;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      tmo_q         <= '0;
      data_q        <= 1'b1;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      poll_sync_q   <= {poll_sync_q[0], poll};
      sample_sync_q <= {sample_sync_q[1:0], sample};
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      tmo_q         <= tmo_d;
      data_q        <= data_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (poll_lvl) state_d = LATCH;
      LATCH: if (!poll_lvl) state_d = SHIFT;
      SHIFT: begin
        // A new poll outranks a simultaneous sample edge and aborts the frame.
        if (poll_lvl)
          state_d = LATCH;
        else if (sample_rise && bit_cnt_q == CNT_W'(WIDTH - 1))
          state_d = DONE;
        else if (!sample_rise && tmo_q == TMO_W'(TIMEOUT - 1))
          state_d = IDLE;
      end
      DONE:    state_d = poll_lvl ? LATCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    if (state_d == LATCH) begin
      shreg_d   = buttons;
      bit_cnt_d = '0;
      tmo_d     = '0;
    end else if (state_q == SHIFT && state_d == SHIFT) begin
      if (sample_rise) begin
        shreg_d   = shreg_q >> 1;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        tmo_d     = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  // Outputs are decoded from next-state values and registered, so they line
  // up with the state they describe and have no combinational input path.
  always_comb begin
    data_d       = 1'b1;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;
    unique case (state_d)
      IDLE: ;
      LATCH, SHIFT: begin
        data_d = ~shreg_d[0];
        busy_d = 1'b1;
      end
      DONE: begin
        data_d       = 1'b0;
        busy_d       = 1'b1;
        frame_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign data       = data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
